// File: rtl/lifo_stack_pkg.sv
// lifo_stack_pkg: shared defaults, width helpers and op codes for the LIFO stack
package lifo_stack_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 16;
  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_PUSH = 2'b10;
  localparam logic [1:0] OP_REPL = 2'b11;
  function automatic int cw_f(input int depth);
    return $clog2(depth + 1);
  endfunction
  function automatic int aw_f(input int depth);
    return (depth > 2) ? $clog2(depth - 1) : 1;
  endfunction
endpackage

// File: rtl/lifo_stack_mem.sv
// lifo_stack_mem: entries below the top, one sync write port and one async read port
module lifo_stack_mem
  import lifo_stack_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CW    = cw_f(DEPTH)
) (
  input  logic             CLK,
  input  logic             we,
  input  logic [CW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic [CW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_dat
);
  localparam int AW = aw_f(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH-1];
  // out-of-range addresses come from count-1/count-2 underflowing on a shallow stack
  always_ff @(posedge CLK)
    if (we && wr_addr < CW'(DEPTH - 1)) mem[wr_addr[AW-1:0]] <= wr_dat;
  assign rd_dat = (rd_addr < CW'(DEPTH - 1)) ? mem[rd_addr[AW-1:0]] : '0;
endmodule

// File: rtl/lifo_stack.sv
// lifo_stack: LIFO with strobe/ack handshakes, registered top, replace-top and sticky error flags
module lifo_stack
  import lifo_stack_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CW    = cw_f(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CLR,
  input  logic             PUSH_STB,
  input  logic [WIDTH-1:0] PUSH_DAT,
  output logic             PUSH_ACK,
  input  logic             POP_STB,
  output logic             POP_ACK,
  output logic [WIDTH-1:0] POP_DAT,
  output logic [WIDTH-1:0] TOP_DAT,
  output logic             EMPTY,
  output logic             FULL,
  output logic [CW-1:0]    COUNT,
  output logic             OVF,
  output logic             UNF
);
  logic [WIDTH-1:0] top_q, top_d, rd_dat;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, unf_q;
  logic [1:0]       op;
  assign EMPTY    = count_q == '0;
  assign FULL     = count_q == CW'(DEPTH);
  assign POP_ACK  = RST_N & ~CLR & POP_STB & ~EMPTY;
  assign PUSH_ACK = RST_N & ~CLR & PUSH_STB & (~FULL | POP_ACK);
  assign POP_DAT  = POP_ACK ? top_q : '0;
  assign TOP_DAT  = top_q;
  assign COUNT    = count_q;
  assign OVF      = ovf_q;
  assign UNF      = unf_q;
  assign op       = {PUSH_ACK, POP_ACK};
  // a plain push spills the old top into storage; replace leaves storage untouched
  lifo_stack_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) u_mem (
    .CLK     (CLK),
    .we      (op == OP_PUSH),
    .wr_addr (count_q - CW'(1)),
    .wr_dat  (top_q),
    .rd_addr (count_q - CW'(2)),
    .rd_dat  (rd_dat)
  );
  always_comb begin
    count_d = (op == OP_PUSH) ? count_q + CW'(1) : (op == OP_POP) ? count_q - CW'(1) : count_q;
    top_d   = PUSH_ACK ? PUSH_DAT : POP_ACK ? rd_dat : top_q;
  end
  always_ff @(posedge CLK) begin
    if (!RST_N || CLR) begin
      count_q <= '0;
      top_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      top_q   <= top_d;
      ovf_q   <= ovf_q | (PUSH_STB & ~PUSH_ACK);
      unf_q   <= unf_q | (POP_STB & EMPTY);
    end
  end
endmodule
